// File: rtl/ram_fifo_pkg.sv
// Shared widths and types for the RAM-backed FIFO controller.
package ram_fifo_pkg;

    localparam int DATA_W     = 8;
    localparam int RAM_ADDR_W = 8;

    typedef logic [DATA_W-1:0]     data_t;
    typedef logic [RAM_ADDR_W-1:0] ram_addr_t;

    // Offset is an already zero-extended pointer; result wraps within the RAM space.
    function automatic ram_addr_t ram_addr(input ram_addr_t base, input ram_addr_t offset);
        return base + offset;
    endfunction

endpackage

// File: rtl/ram_fifo_ptr.sv
// Wrapping FIFO pointer: increments on inc, returns to zero on srst or clr.
module ram_fifo_ptr #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    localparam logic [W-1:0] PTR_ONE = W'(1);

    logic [W-1:0] ptr_reg;
    logic [W-1:0] ptr_next;

    always_comb begin
        ptr_next = ptr_reg;
        if (clr) begin
            ptr_next = '0;
        end else if (inc) begin
            ptr_next = ptr_reg + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Single-port RAM FIFO controller: arbitrates push/pop onto one RAM port.
// Optional synchronous flush input when RAM_FIFO_FLUSH_EN is defined.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int        DEPTH_LOG2 = 5,
    parameter ram_addr_t BASE_ADDR  = 8'd0
) (
    input  logic                  clock,
    input  logic                  reset,
`ifdef RAM_FIFO_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic                  push,
    input  data_t                 pushData,
    output logic                  pushAck,
    input  logic                  pop,
    output logic                  popAck,
    output logic                  popValid,
    output data_t                 popData,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output ram_addr_t             ramAddress,
    output logic                  ramWE,
    output data_t                 ramDataIn,
    input  data_t                 ramDataOut
);

    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] CNT_ONE    = (DEPTH_LOG2 + 1)'(1);

    logic                  flush_i;
    logic                  blocked;
    logic                  push_ok;
    logic                  pop_ok;
    logic                  contested;
    logic                  grant_push;
    logic                  grant_pop;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count_reg;
    logic [DEPTH_LOG2:0]   count_next;
    logic                  pop_first_reg;
    logic                  pop_valid_reg;

`ifdef RAM_FIFO_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    // Acks depend only on requests and registered state, never on ramDataOut.
    assign blocked    = reset | flush_i;
    assign push_ok    = push & ~full & ~blocked;
    assign pop_ok     = pop & ~empty & ~blocked;
    assign contested  = push_ok & pop_ok;
    assign grant_pop  = pop_ok & (~push_ok | pop_first_reg);
    assign grant_push = push_ok & (~pop_ok | ~pop_first_reg);

    assign pushAck = grant_push;
    assign popAck  = grant_pop;

    assign full  = (count_reg == FULL_COUNT);
    assign empty = (count_reg == '0);
    assign count = count_reg;

    ram_fifo_ptr #(.W(DEPTH_LOG2)) u_wr_ptr (
        .clk  (clock),
        .srst (reset),
        .clr  (flush_i),
        .inc  (grant_push),
        .ptr  (wr_ptr)
    );

    ram_fifo_ptr #(.W(DEPTH_LOG2)) u_rd_ptr (
        .clk  (clock),
        .srst (reset),
        .clr  (flush_i),
        .inc  (grant_pop),
        .ptr  (rd_ptr)
    );

    // Idle cycles park the address on the read pointer.
    assign ramWE      = grant_push;
    assign ramDataIn  = pushData;
    assign ramAddress = grant_push ? ram_addr(BASE_ADDR, ram_addr_t'(wr_ptr))
                                   : ram_addr(BASE_ADDR, ram_addr_t'(rd_ptr));

    always_comb begin
        count_next = count_reg;
        if (grant_push) begin
            count_next = count_reg + CNT_ONE;
        end else if (grant_pop) begin
            count_next = count_reg - CNT_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_reg     <= '0;
            pop_first_reg <= 1'b1;
            pop_valid_reg <= 1'b0;
        end else begin
            count_reg     <= flush_i ? '0 : count_next;
            pop_valid_reg <= grant_pop;
            if (contested) begin
                pop_first_reg <= ~pop_first_reg;
            end
        end
    end

    // Reset masks a read result that is already in flight.
    assign popValid = pop_valid_reg & ~reset;

    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_pop_data
        assign popData[gi] = popValid & ramDataOut[gi];
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural 256x8 synchronous RAM.
// Flush checks are included when RAM_FIFO_FLUSH_EN is defined.
module tb_ram_fifo_ctrl;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A: BASE_ADDR = 0
    logic       rst_a, push_a, pop_a, flush_a;
    logic [7:0] push_data_a;
    logic       push_ack_a, pop_ack_a, pop_valid_a, full_a, empty_a, ram_we_a;
    logic [7:0] pop_data_a, ram_addr_a, ram_din_a, ram_dout_a;
    logic [5:0] count_a;
    logic [7:0] mem_a [256];

    // Instance B: BASE_ADDR = 8
    logic       rst_b, push_b, pop_b, flush_b;
    logic [7:0] push_data_b;
    logic       push_ack_b, pop_ack_b, pop_valid_b, full_b, empty_b, ram_we_b;
    logic [7:0] pop_data_b, ram_addr_b, ram_din_b, ram_dout_b;
    logic [5:0] count_b;
    logic [7:0] mem_b [256];

    ram_fifo_ctrl #(.DEPTH_LOG2(5), .BASE_ADDR(8'd0)) dut_a (
        .clock      (clk),
        .reset      (rst_a),
`ifdef RAM_FIFO_FLUSH_EN
        .flush      (flush_a),
`endif
        .push       (push_a),
        .pushData   (push_data_a),
        .pushAck    (push_ack_a),
        .pop        (pop_a),
        .popAck     (pop_ack_a),
        .popValid   (pop_valid_a),
        .popData    (pop_data_a),
        .full       (full_a),
        .empty      (empty_a),
        .count      (count_a),
        .ramAddress (ram_addr_a),
        .ramWE      (ram_we_a),
        .ramDataIn  (ram_din_a),
        .ramDataOut (ram_dout_a)
    );

    ram_fifo_ctrl #(.DEPTH_LOG2(5), .BASE_ADDR(8'd8)) dut_b (
        .clock      (clk),
        .reset      (rst_b),
`ifdef RAM_FIFO_FLUSH_EN
        .flush      (flush_b),
`endif
        .push       (push_b),
        .pushData   (push_data_b),
        .pushAck    (push_ack_b),
        .pop        (pop_b),
        .popAck     (pop_ack_b),
        .popValid   (pop_valid_b),
        .popData    (pop_data_b),
        .full       (full_b),
        .empty      (empty_b),
        .count      (count_b),
        .ramAddress (ram_addr_b),
        .ramWE      (ram_we_b),
        .ramDataIn  (ram_din_b),
        .ramDataOut (ram_dout_b)
    );

    always @(posedge clk) begin
        if (ram_we_a) mem_a[ram_addr_a] <= ram_din_a;
        else          ram_dout_a <= mem_a[ram_addr_a];
        if (ram_we_b) mem_b[ram_addr_b] <= ram_din_b;
        else          ram_dout_b <= mem_b[ram_addr_b];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s got=%0d", tag, got);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        rst_a = 1'b1; push_a = 1'b0; pop_a = 1'b0; flush_a = 1'b0;
        nxt();
        rst_a = 1'b0;
    endtask

    int pulses;
    logic [3:0] pop_win;

    initial begin
        rst_a = 1'b1; push_a = 1'b1; pop_a = 1'b1; flush_a = 1'b0; push_data_a = 8'd3;
        rst_b = 1'b1; push_b = 1'b0; pop_b = 1'b0; flush_b = 1'b0; push_data_b = 8'd0;
        #1;
        chk("rst_push_ack", push_ack_a, 0);
        chk("rst_pop_ack", pop_ack_a, 0);
        chk("rst_ram_we", ram_we_a, 0);
        nxt();
        nxt();
        rst_a = 1'b0; rst_b = 1'b0; push_a = 1'b0; pop_a = 1'b0;
        #1;
        chk("rst_count", count_a, 0);
        chk("rst_empty", empty_a, 1);
        chk("rst_full", full_a, 0);
        chk("rst_pop_valid", pop_valid_a, 0);
        chk("rst_pop_data", pop_data_a, 0);

        // Single push then pop
        push_a = 1'b1; push_data_a = 8'd10;
        #1;
        chk("p1_push_ack", push_ack_a, 1);
        chk("p1_ram_we", ram_we_a, 1);
        chk("p1_ram_addr", ram_addr_a, 0);
        nxt();
        push_a = 1'b0; pop_a = 1'b1;
        #1;
        chk("p1_pop_ack", pop_ack_a, 1);
        chk("p1_pop_addr", ram_addr_a, 0);
        chk("p1_count", count_a, 1);
        nxt();
        pop_a = 1'b0;
        #1;
        chk("p1_pop_valid", pop_valid_a, 1);
        chk("p1_pop_data", pop_data_a, 10);
        chk("p1_empty", empty_a, 1);

        // Base address offset on instance B
        push_b = 1'b1; push_data_b = 8'd15;
        #1;
        chk("b_push_addr", ram_addr_b, 8);
        chk("b_push_we", ram_we_b, 1);
        nxt();
        push_b = 1'b0; pop_b = 1'b1;
        #1;
        chk("b_pop_addr", ram_addr_b, 8);
        chk("b_pop_ack", pop_ack_b, 1);
        nxt();
        pop_b = 1'b0;
        #1;
        chk("b_pop_data", pop_data_b, 15);

        // Fill to full, reject one more, drain in order
        reset_a();
        for (int i = 0; i < 32; i++) begin
            push_a = 1'b1; push_data_a = 8'(i);
            #1;
            chk($sformatf("fill_ack_%0d", i), push_ack_a, 1);
            nxt();
        end
        push_a = 1'b1; push_data_a = 8'd99;
        #1;
        chk("full_flag", full_a, 1);
        chk("full_count", count_a, 32);
        chk("push33_ack", push_ack_a, 0);
        push_a = 1'b0;
        for (int i = 0; i < 32; i++) begin
            pop_a = 1'b1;
            #1;
            chk($sformatf("drain_ack_%0d", i), pop_ack_a, 1);
            if (i > 0) chk($sformatf("drain_data_%0d", i - 1), pop_data_a, i - 1);
            nxt();
        end
        pop_a = 1'b0;
        #1;
        chk("drain_data_31", pop_data_a, 31);
        chk("drain_empty", empty_a, 1);
        chk("drain_rd_wrap", ram_addr_a, 0);

        // Contested push/pop at count 4
        reset_a();
        for (int i = 0; i < 4; i++) begin
            push_a = 1'b1; push_data_a = 8'(40 + i);
            nxt();
        end
        pop_win = 4'b0101;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            push_a = 1'b1; pop_a = 1'b1;
            push_data_a = (k < 2) ? 8'd50 : 8'd51;
            #1;
            chk($sformatf("arb_pop_ack_%0d", k), pop_ack_a, pop_win[k]);
            chk($sformatf("arb_push_ack_%0d", k), push_ack_a, !pop_win[k]);
            if (pop_valid_a) pulses++;
            if (k == 1) chk("arb_data_0", pop_data_a, 40);
            if (k == 3) chk("arb_data_1", pop_data_a, 41);
            nxt();
        end
        push_a = 1'b0; pop_a = 1'b0;
        #1;
        if (pop_valid_a) pulses++;
        chk("arb_count", count_a, 4);
        chk("arb_pulses", pulses, 2);

        // Empty with push and pop: push wins
        reset_a();
        push_a = 1'b1; pop_a = 1'b1; push_data_a = 8'd77;
        #1;
        chk("ep_push_ack", push_ack_a, 1);
        chk("ep_pop_ack", pop_ack_a, 0);
        nxt();
        push_a = 1'b0;
        #1;
        chk("ep_pop_ack2", pop_ack_a, 1);
        nxt();
        pop_a = 1'b0;
        #1;
        chk("ep_pop_valid", pop_valid_a, 1);
        chk("ep_pop_data", pop_data_a, 77);

        // Reset right after a pop grant cancels the result
        reset_a();
        push_a = 1'b1; push_data_a = 8'd9;
        nxt();
        push_a = 1'b0; pop_a = 1'b1;
        #1;
        chk("rp_pop_ack", pop_ack_a, 1);
        nxt();
        pop_a = 1'b0; rst_a = 1'b1;
        #1;
        chk("rp_valid_in_rst", pop_valid_a, 0);
        nxt();
        rst_a = 1'b0;
        #1;
        chk("rp_valid_after", pop_valid_a, 0);
        chk("rp_count", count_a, 0);

`ifdef RAM_FIFO_FLUSH_EN
        reset_a();
        for (int i = 0; i < 5; i++) begin
            push_a = 1'b1; push_data_a = 8'(60 + i);
            nxt();
        end
        push_a = 1'b0;
        #1;
        chk("fl_count5", count_a, 5);
        push_a = 1'b1; pop_a = 1'b1; flush_a = 1'b1;
        #1;
        chk("fl_push_ack", push_ack_a, 0);
        chk("fl_pop_ack", pop_ack_a, 0);
        nxt();
        push_a = 1'b0; pop_a = 1'b0; flush_a = 1'b0;
        #1;
        chk("fl_empty", empty_a, 1);
        chk("fl_count", count_a, 0);
        chk("fl_pop_valid", pop_valid_a, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
